// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers.
// It passes lamp codes through, and on any fault it latches an all-yellow flash until reset.
module signal_conflict_monitor #(
   parameter int STARTUP_CYC = 8,
   parameter int FILTER_CYC  = 2,
   parameter int BLINK_HALF  = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] main_lr_in,
   input  logic [2:0] main_lr_side,
   input  logic [2:0] main_rl_side,
   input  logic [2:0] side_lr_in,
   output logic [2:0] main_lr_lamp,
   output logic [2:0] lr_side_lamp,
   output logic [2:0] rl_side_lamp,
   output logic [2:0] side_lr_lamp,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] DRK = 3'b000;

   localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
   localparam int FW = (FILTER_CYC  > 1) ? $clog2(FILTER_CYC)  : 1;
   localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_PASS  = 2'd1,
      ST_FLASH = 2'd2
   } state_t;

   state_t          state;
   logic [SW-1:0]   start_cnt;
   logic [FW-1:0]   filt_cnt;
   logic [BW-1:0]   blink_cnt;
   logic            blink_on;
   logic [3:0][2:0] cur;
   logic [3:0][2:0] prev;
   logic [3:0][2:0] lamps;

   logic       illegal;
   logic       conflict;
   logic       skip;
   logic       bad;
   logic       filt_hit;
   logic       trip;
   logic [1:0] trip_code;

   // Lane order: 0 main through, 1 main lr turn, 2 main rl turn, 3 side road.
   assign cur = {side_lr_in, main_rl_side, main_lr_side, main_lr_in};

   assign main_lr_lamp = lamps[0];
   assign lr_side_lamp = lamps[1];
   assign rl_side_lamp = lamps[2];
   assign side_lr_lamp = lamps[3];

   always_comb begin
      illegal = 1'b0;
      skip    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!(cur[i] == RED || cur[i] == YEL || cur[i] == GRN)) illegal = 1'b1;
         if (prev[i] == GRN && cur[i] == RED) skip = 1'b1;
      end
      conflict = ((cur[3] == GRN) && (cur[0] == GRN || cur[1] == GRN || cur[2] == GRN)) ||
                 ((cur[1] == GRN) && (cur[2] == GRN));
      bad      = illegal | conflict;
      filt_hit = bad && (filt_cnt == FW'(FILTER_CYC - 1));
      trip     = filt_hit | skip;
      // Filtered faults outrank the skip fault; illegal outranks conflict.
      trip_code = filt_hit ? (illegal ? 2'd1 : 2'd2) : 2'd3;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_INIT;
         start_cnt  <= '0;
         filt_cnt   <= '0;
         blink_cnt  <= '0;
         blink_on   <= 1'b1;
         prev       <= {4{RED}};
         lamps      <= {4{RED}};
         fault      <= 1'b0;
         fault_code <= 2'd0;
      end else begin
         case (state)
            ST_INIT: begin
               lamps    <= {4{RED}};
               prev     <= cur;
               filt_cnt <= '0;
               if (start_cnt == SW'(STARTUP_CYC - 1)) state <= ST_PASS;
               else start_cnt <= start_cnt + 1'b1;
            end
            ST_PASS: begin
               prev <= cur;
               if (trip) begin
                  state      <= ST_FLASH;
                  fault      <= 1'b1;
                  fault_code <= trip_code;
                  lamps      <= {4{YEL}};
                  blink_cnt  <= '0;
                  blink_on   <= 1'b1;
               end else begin
                  lamps    <= cur;
                  filt_cnt <= bad ? filt_cnt + 1'b1 : '0;
               end
            end
            ST_FLASH: begin
               // Lamps are registered from the phase that will hold after this edge.
               if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                  blink_cnt <= '0;
                  blink_on  <= ~blink_on;
                  lamps     <= blink_on ? {4{DRK}} : {4{YEL}};
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
                  lamps     <= blink_on ? {4{YEL}} : {4{DRK}};
               end
            end
            default: begin
               state      <= ST_FLASH;
               fault      <= 1'b1;
               fault_code <= 2'd1;
               lamps      <= {4{YEL}};
               blink_cnt  <= '0;
               blink_on   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Bench for signal_conflict_monitor: directed scenarios plus random traffic,
// checked against a cycle-count based reference model.
module tb_signal_conflict_monitor;

   localparam int STARTUP = 8;
   localparam int FILTER  = 2;
   localparam int BH      = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] main_lr_in = 3'b100, main_lr_side = 3'b100, main_rl_side = 3'b100, side_lr_in = 3'b100;
   logic [2:0] main_lr_lamp, lr_side_lamp, rl_side_lamp, side_lr_lamp;
   logic       fault;
   logic [1:0] fault_code;

   int checks = 0;
   int fails  = 0;

   // model state
   int         m_since, m_run, m_age;
   bit         m_tripped;
   logic [2:0] m_prev [4];
   logic [2:0] e_lamp [4];
   logic       e_fault;
   logic [1:0] e_code;

   signal_conflict_monitor #(.STARTUP_CYC(STARTUP), .FILTER_CYC(FILTER), .BLINK_HALF(BH)) dut (
      .clk(clk), .reset(reset),
      .main_lr_in(main_lr_in), .main_lr_side(main_lr_side),
      .main_rl_side(main_rl_side), .side_lr_in(side_lr_in),
      .main_lr_lamp(main_lr_lamp), .lr_side_lamp(lr_side_lamp),
      .rl_side_lamp(rl_side_lamp), .side_lr_lamp(side_lr_lamp),
      .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] got_vec();
      return {main_lr_lamp, lr_side_lamp, rl_side_lamp, side_lr_lamp, fault, fault_code};
   endfunction

   function automatic logic [14:0] exp_vec();
      return {e_lamp[0], e_lamp[1], e_lamp[2], e_lamp[3], e_fault, e_code};
   endfunction

   task automatic model_step();
      logic [2:0] c [4];
      bit ill, conf, skp, bad;
      logic [1:0] code;
      c = '{main_lr_in, main_lr_side, main_rl_side, side_lr_in};
      if (reset) begin
         m_since = 0; m_run = 0; m_age = 0; m_tripped = 0;
         e_fault = 0; e_code = 0;
         for (int i = 0; i < 4; i++) begin m_prev[i] = 3'b100; e_lamp[i] = 3'b100; end
      end else if (m_tripped) begin
         m_age++;
         for (int i = 0; i < 4; i++) e_lamp[i] = (((m_age / BH) % 2) == 0) ? 3'b010 : 3'b000;
      end else if (m_since < STARTUP) begin
         m_since++;
         for (int i = 0; i < 4; i++) begin m_prev[i] = c[i]; e_lamp[i] = 3'b100; end
      end else begin
         ill = 0; skp = 0;
         for (int i = 0; i < 4; i++) begin
            if (!(c[i] inside {3'b100, 3'b010, 3'b001})) ill = 1;
            if (m_prev[i] == 3'b001 && c[i] == 3'b100) skp = 1;
         end
         conf = (c[3] == 3'b001 && c[0] == 3'b001) || (c[3] == 3'b001 && c[1] == 3'b001) ||
                (c[3] == 3'b001 && c[2] == 3'b001) || (c[1] == 3'b001 && c[2] == 3'b001);
         bad   = ill || conf;
         m_run = bad ? m_run + 1 : 0;
         code  = 0;
         if (bad && m_run >= FILTER) code = ill ? 2'd1 : 2'd2;
         else if (skp) code = 2'd3;
         if (code != 0) begin
            m_tripped = 1; m_age = 0; e_fault = 1; e_code = code;
            for (int i = 0; i < 4; i++) e_lamp[i] = 3'b010;
         end else begin
            for (int i = 0; i < 4; i++) e_lamp[i] = c[i];
         end
         for (int i = 0; i < 4; i++) m_prev[i] = c[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
      main_lr_in = a; main_lr_side = b; main_rl_side = c; side_lr_in = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [2:0] rand_code();
      int r;
      r = $urandom_range(0, 31);
      if (r < 14) return 3'b100;
      if (r < 22) return 3'b010;
      if (r < 30) return 3'b001;
      return 3'($urandom_range(0, 7));
   endfunction

   task automatic test_reset();
      set_in(3'b001, 3'b001, 3'b100, 3'b100);
      do_reset();
      checks++;
      if (got_vec() !== {12'b100_100_100_100, 1'b0, 2'd0}) begin
         fails++; $display("FAIL reset_state got=%h exp=%h", got_vec(), {12'b100_100_100_100, 3'b0});
      end
      for (int k = 1; k <= STARTUP + 3; k++) begin
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            fails++; $display("FAIL startup cyc=%0d got=%h exp=%h", k, got_vec(), exp_vec());
         end
         if (k == STARTUP + 1) begin
            checks++;
            if (got_vec() !== {12'b001_001_100_100, 3'b0}) begin
               fails++; $display("FAIL first_pass got=%h exp=%h", got_vec(), {12'b001_001_100_100, 3'b0});
            end
         end
      end
   endtask

   task automatic startup_red();
      set_in(3'b100, 3'b100, 3'b100, 3'b100);
      do_reset();
      for (int k = 0; k < STARTUP; k++) tick();
   endtask

   task automatic test_legal_sequence();
      logic [11:0] seq [6];
      seq = '{12'b001_001_100_100, 12'b010_010_100_100, 12'b100_100_001_100,
              12'b100_100_010_100, 12'b100_100_100_001, 12'b100_100_100_010};
      startup_red();
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < 6; s++) begin
            set_in(seq[s][11:9], seq[s][8:6], seq[s][5:3], seq[s][2:0]);
            for (int h = $urandom_range(1, 3); h > 0; h--) begin
               tick();
               checks++;
               if (got_vec() !== exp_vec()) begin
                  fails++; $display("FAIL legal_seq r=%0d s=%0d got=%h exp=%h", r, s, got_vec(), exp_vec());
               end
            end
         end
      checks++;
      if (fault !== 1'b0) begin fails++; $display("FAIL legal_no_fault got=%b exp=0", fault); end
   endtask

   task automatic test_conflict_filter();
      startup_red();
      set_in(3'b001, 3'b100, 3'b100, 3'b001);
      tick();
      set_in(3'b010, 3'b100, 3'b100, 3'b010);
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (got_vec() !== exp_vec() || fault !== 1'b0) begin
            fails++; $display("FAIL glitch_no_trip got=%h exp=%h", got_vec(), exp_vec());
         end
      end
      set_in(3'b001, 3'b100, 3'b100, 3'b001);
      tick();
      checks++;
      if (fault !== 1'b0) begin fails++; $display("FAIL conflict_1st got=%b exp=0", fault); end
      tick();
      checks++;
      if (got_vec() !== {12'b010_010_010_010, 1'b1, 2'd2}) begin
         fails++; $display("FAIL conflict_trip got=%h exp=%h", got_vec(), {12'b010_010_010_010, 3'b110});
      end
   endtask

   task automatic test_skip();
      set_in(3'b100, 3'b001, 3'b100, 3'b100);
      do_reset();
      for (int k = 0; k <= STARTUP; k++) tick();
      checks++;
      if (got_vec() !== exp_vec() || fault !== 1'b0) begin
         fails++; $display("FAIL skip_pre got=%h exp=%h", got_vec(), exp_vec());
      end
      main_lr_side = 3'b100;
      tick();
      checks++;
      if (got_vec() !== {12'b010_010_010_010, 1'b1, 2'd3}) begin
         fails++; $display("FAIL skip_trip got=%h exp=%h", got_vec(), {12'b010_010_010_010, 3'b111});
      end
   endtask

   task automatic test_illegal_flash();
      logic [2:0] pat;
      startup_red();
      set_in(3'b011, 3'b001, 3'b100, 3'b001);
      tick();
      tick();
      checks++;
      if (got_vec() !== {12'b010_010_010_010, 1'b1, 2'd1}) begin
         fails++; $display("FAIL illegal_trip got=%h exp=%h", got_vec(), {12'b010_010_010_010, 3'b101});
      end
      for (int k = 1; k <= 4 * BH; k++) begin
         set_in(rand_code(), rand_code(), rand_code(), rand_code());
         tick();
         pat = (((k / BH) % 2) == 0) ? 3'b010 : 3'b000;
         checks++;
         if (got_vec() !== {pat, pat, pat, pat, 1'b1, 2'd1} || got_vec() !== exp_vec()) begin
            fails++; $display("FAIL flash k=%0d got=%h exp=%h", k, got_vec(), {pat, pat, pat, pat, 3'b101});
         end
      end
   endtask

   task automatic test_reset_in_flash();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (got_vec() !== {12'b100_100_100_100, 3'b0}) begin
         fails++; $display("FAIL flash_reset got=%h exp=%h", got_vec(), {12'b100_100_100_100, 3'b0});
      end
      set_in(3'b001, 3'b100, 3'b100, 3'b100);
      for (int k = 1; k <= STARTUP + 4; k++) begin
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            fails++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", k, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         set_in(rand_code(), rand_code(), rand_code(), rand_code());
         do_reset();
         for (int k = 0; k < 60; k++) begin
            set_in(rand_code(), rand_code(), rand_code(), rand_code());
            reset = ($urandom_range(0, 49) == 0);
            tick();
            reset = 1'b0;
            checks++;
            if (got_vec() !== exp_vec()) begin
               fails++; $display("FAIL random r=%0d k=%0d got=%h exp=%h", r, k, got_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_legal_sequence();
      test_conflict_filter();
      test_skip();
      test_illegal_flash();
      test_reset_in_flash();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
